// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter4_grant_dec.sv
// Combinational index-to-one-hot decoder; output is all-zero when en is low.
module rr_grant_dec
    import rr_arbiter4_pkg::*;
(
    input  logic [1:0]         idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold limit. Grant registered one edge after
// request is sampled in IDLE; every tenure ends with a one-cycle RELEASE gap.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_n;
    logic [1:0]        owner, owner_n;
    logic [1:0]        ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              timeout_n;

    logic [1:0]        sel_idx;
    logic              sel_vld;
    logic              owner_req;
    logic              at_limit;
    logic              grant_en;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                sel_idx = ptr + 2'(k);
                sel_vld = 1'b1;
            end
        end
    end

    assign owner_req = req[owner];
    assign at_limit  = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    owner_n    = sel_idx;
                    hold_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (done || !owner_req || at_limit) begin
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_n = at_limit && !done && owner_req;
                    state_n   = RELEASE;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                ptr_n   = owner + 2'd1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end

    assign grant_en  = (state == GRANT);
    assign gnt_idx   = grant_en ? owner : 2'd0;
    assign gnt_valid = grant_en;

    rr_grant_dec u_dec (
        .idx    (owner),
        .en     (grant_en),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scenarios then random traffic, checked against a cycle-level reference model.
module tb_rr_arbiter4;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    // Reference model: phase 0 = idle, 1 = granted, 2 = release gap.
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [3:0] r, input logic d, input logic rs);
        if (rs) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_to = 1'b0;
        end else if (m_phase == 0) begin
            m_to = 1'b0;
            if (r != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                end
                m_cnt   = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (d || !r[m_owner] || m_cnt == MAXH - 1) begin
                m_to    = (m_cnt == MAXH - 1) && !d && r[m_owner];
                m_phase = 2;
            end else begin
                m_cnt++;
                m_to = 1'b0;
            end
        end else begin
            m_to    = 1'b0;
            m_ptr   = (m_owner + 1) % 4;
            m_phase = 0;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic rs);
        logic [3:0] e_gnt;
        logic [1:0] e_idx;
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_update(r, d, rs);
        #1;
        e_gnt = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e_idx = (m_phase == 1) ? 2'(m_owner) : 2'd0;
        chk("model_gnt",       8'(gnt),       8'(e_gnt));
        chk("model_gnt_idx",   8'(gnt_idx),   8'(e_idx));
        chk("model_gnt_valid", 8'(gnt_valid), 8'(m_phase == 1));
        chk("model_timeout",   8'(timeout),   8'(m_to));
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            assert ($onehot0(gnt) && (gnt_valid === (gnt != 4'b0000))) else begin
                miscompares++;
                $error("FAIL onehot gnt=%b gnt_valid=%b required onehot0 and valid==|gnt", gnt, gnt_valid);
            end
        end
    end

    initial begin
        int order_a [4];
        int order_b [5];
        logic [3:0] r;
        logic       d;
        logic       rs;
        order_a = '{0, 2, 0, 2};
        order_b = '{0, 1, 2, 3, 0};
        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b1;

        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("reset_gnt",     8'(gnt),       8'h00);
        chk("reset_valid",   8'(gnt_valid), 8'h00);
        chk("reset_timeout", 8'(timeout),   8'h00);

        // Alternating pair with done each tenure.
        for (int t = 0; t < 4; t++) begin
            step(4'b0101, 1'b0, 1'b0);
            chk("pair_grant", 8'(gnt), 8'(4'b0001 << order_a[t]));
            step(4'b0101, 1'b1, 1'b0);
            chk("pair_release", 8'(gnt), 8'h00);
            step(4'b0101, 1'b0, 1'b0);
        end

        // All requesting, two grant cycles per tenure.
        step(4'b1111, 1'b0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            step(4'b1111, 1'b0, 1'b0);
            chk("all_grant", 8'(gnt_idx), 8'(order_b[t]));
            step(4'b1111, 1'b0, 1'b0);
            chk("all_hold", 8'(gnt_idx), 8'(order_b[t]));
            step(4'b1111, 1'b1, 1'b0);
            chk("all_release", 8'(gnt), 8'h00);
            step(4'b1111, 1'b0, 1'b0);
        end

        // Hold limit forces a release with a timeout pulse.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < MAXH; i++) begin
            step(4'b0010, 1'b0, 1'b0);
            chk("hold_gnt", 8'(gnt), 8'h02);
        end
        step(4'b0010, 1'b0, 1'b0);
        chk("hold_timeout", 8'(timeout), 8'h01);
        chk("hold_gap_gnt", 8'(gnt), 8'h00);
        step(4'b0110, 1'b0, 1'b0);
        chk("hold_timeout_once", 8'(timeout), 8'h00);
        step(4'b0110, 1'b0, 1'b0);
        chk("hold_next_owner", 8'(gnt), 8'h04);
        step(4'b0110, 1'b1, 1'b0);

        // Owner drops its request; then reset in the middle of a grant.
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        chk("drop_grant", 8'(gnt), 8'h04);
        step(4'b0000, 1'b0, 1'b0);
        chk("drop_release", 8'(gnt), 8'h00);
        chk("drop_no_timeout", 8'(timeout), 8'h00);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        chk("drop_ptr3", 8'(gnt), 8'h08);
        step(4'b1111, 1'b0, 1'b1);
        chk("midgrant_reset", 8'(gnt), 8'h00);
        step(4'b1001, 1'b0, 1'b0);
        chk("post_reset_grant", 8'(gnt), 8'h01);
        step(4'b1001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        // done coincides with the hold limit.
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < MAXH; i++) begin
            step(4'b0001, 1'b0, 1'b0);
        end
        chk("coincide_last_gnt", 8'(gnt), 8'h01);
        step(4'b0001, 1'b1, 1'b0);
        chk("coincide_no_timeout", 8'(timeout), 8'h00);
        chk("coincide_release", 8'(gnt), 8'h00);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            r  = 4'($urandom_range(0, 15));
            d  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(r, d, rs);
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
